// File: rtl/dlx_pkg.sv
// Shared constants and types for the DLX phase sequencer.
package dlx_pkg;

  // Canonical phase indices of the classic 5-phase DLX instruction cycle.
  localparam int unsigned PH_IF  = 0;
  localparam int unsigned PH_ID  = 1;
  localparam int unsigned PH_EX  = 2;
  localparam int unsigned PH_MEM = 3;
  localparam int unsigned PH_WB  = 4;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/dlx_phase_pick.sv
// Next-phase picker: lowest phase index above cur_idx that is not masked.
// last is raised when no such phase exists, i.e. the instruction ends.
module dlx_phase_pick #(
  parameter int unsigned NPHASE = 5,
  parameter int unsigned IW     = $clog2(NPHASE)
) (
  input  logic [IW-1:0]     cur_idx,
  input  logic [NPHASE-1:0] msk,
  output logic [IW-1:0]     nxt_idx,
  output logic              last
);

  // Priority search upward from the current phase; first unmasked phase wins.
  always_comb begin
    nxt_idx = '0;
    last    = 1'b1;
    for (int unsigned j = 0; j < NPHASE; j++) begin
      if (last && (j > 32'(cur_idx)) && !msk[j]) begin
        nxt_idx = IW'(j);
        last    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dlx_phase_seq.sv
// Parametrised multicycle phase sequencer for the DLX core.
// Optional build macro PHASE_SEQ_STEP_EN adds single-instruction debug stepping
// (ports dbg_step_mode, dbg_step).
module dlx_phase_seq
  import dlx_pkg::*;
#(
  parameter int unsigned NPHASE    = 5,
  parameter int unsigned DECODE_PH = PH_ID,
  parameter int unsigned TMO_W     = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NPHASE-1:0]         phase_ready,
  input  logic [NPHASE-1:0]         skip_mask,
  input  logic                      halt,
`ifdef PHASE_SEQ_STEP_EN
  input  logic                      dbg_step_mode,
  input  logic                      dbg_step,
`endif
  output logic [NPHASE-1:0]         phase_oh,
  output logic [$clog2(NPHASE)-1:0] phase_idx,
  output logic                      phase_first,
  output logic                      instr_done,
  output logic                      halted,
  output logic [CNT_W-1:0]          instr_cnt,
  output logic                      tmo_err
);

  localparam int unsigned IW = $clog2(NPHASE);
  // Phases up to and including decode can never be skipped.
  localparam logic [NPHASE-1:0] LOW_MASK = NPHASE'((64'd1 << (DECODE_PH + 1)) - 64'd1);
  localparam logic [NPHASE-1:0] OH0      = NPHASE'(1);
  localparam logic [TMO_W-1:0]  TMO_MAX  = '1;

  seq_state_t        state;
  logic [NPHASE-1:0] cap_mask;
  logic [NPHASE-1:0] msk;
  logic [TMO_W-1:0]  wd_cnt;
  logic [IW-1:0]     nxt_idx;
  logic              last;
  logic              ready_cur;
  logic              is_decode;
  logic              hold_req;
  logic              rel_req;

  // Completion detect and effective skip mask (live value on the decode completion cycle).
  always_comb begin
    ready_cur = phase_ready[phase_idx];
    is_decode = (phase_idx == IW'(DECODE_PH));
    msk       = (is_decode ? skip_mask : cap_mask) & ~LOW_MASK;
  end

  // Boundary hold request and HALT release condition.
  always_comb begin
`ifdef PHASE_SEQ_STEP_EN
    hold_req = halt | dbg_step_mode;
    rel_req  = !hold_req || dbg_step;
`else
    hold_req = halt;
    rel_req  = !halt;
`endif
  end

  dlx_phase_pick #(
    .NPHASE (NPHASE),
    .IW     (IW)
  ) u_pick (
    .cur_idx (phase_idx),
    .msk     (msk),
    .nxt_idx (nxt_idx),
    .last    (last)
  );

  // Instruction-end pulse lives on the completion cycle itself.
  always_comb begin
    instr_done = reset_n && (state == S_RUN) && ready_cur && last;
  end

  // Sequencer FSM, mask capture, retire counter and stall watchdog.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_RUN;
      phase_idx   <= '0;
      phase_oh    <= OH0;
      phase_first <= 1'b1;
      halted      <= 1'b0;
      instr_cnt   <= '0;
      tmo_err     <= 1'b0;
      cap_mask    <= '0;
      wd_cnt      <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (ready_cur) begin
            wd_cnt <= '0;
            if (last) begin
              instr_cnt <= instr_cnt + CNT_W'(1);
              cap_mask  <= '0;
              phase_idx <= '0;
              if (hold_req) begin
                state       <= S_HALT;
                phase_oh    <= '0;
                phase_first <= 1'b0;
                halted      <= 1'b1;
              end else begin
                phase_oh    <= OH0;
                phase_first <= 1'b1;
              end
            end else begin
              if (is_decode) cap_mask <= msk;
              phase_idx   <= nxt_idx;
              phase_oh    <= OH0 << nxt_idx;
              phase_first <= 1'b1;
            end
          end else begin
            phase_first <= 1'b0;
            // Saturating stall count; the error flag rises as the count reaches its ceiling.
            if (wd_cnt != TMO_MAX) begin
              wd_cnt <= wd_cnt + TMO_W'(1);
              if (wd_cnt == TMO_MAX - TMO_W'(1)) tmo_err <= 1'b1;
            end
          end
        end
        S_HALT: begin
          phase_first <= 1'b0;
          if (rel_req) begin
            state       <= S_RUN;
            phase_idx   <= '0;
            phase_oh    <= OH0;
            phase_first <= 1'b1;
            halted      <= 1'b0;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule
